glip_loopback_buffer: RTL and testbench
=======================================

Name: glip_loopback_buffer

Overview:
Parametrised loopback and traffic block between the GLIP logic-side FIFO ports (fifo_in from host, fifo_out to host), for use in place of a direct wire loopback.
- Decouples the two directions with a DEPTH-entry buffer.
- Adds two runtime modes beside plain loopback: a counter-pattern generator (host-read bandwidth tests) and a pattern checker (host-write integrity tests).
- Exposes fill level, error and transfer counters for debug readout.

Parameters:
WIDTH, 16, data word width in bits; must be >= 2.
DEPTH, 16, buffer entries; must be a power of two and >= 2.
CNT_W, 32, width of the transfer counter.

Ports:
clk  in  1  single clock, shared by the io and logic sides.
rst  in  1  asynchronous, active-low reset.
mode  in  2  requested mode: 0 LOOP, 1 GEN, 2 CHECK, 3 treated as LOOP.
in_data  in  WIDTH  word from glip fifo_in_data.
in_valid  in  1  from glip fifo_in_valid.
in_ready  out  1  to glip fifo_in_ready.
out_data  out  WIDTH  to glip fifo_out_data.
out_valid  out  1  to glip fifo_out_valid.
out_ready  in  1  from glip fifo_out_ready.
active_mode  out  2  mode currently in effect.
fill  out  $clog2(DEPTH)+1  number of buffered words.
err_count  out  16  checker mismatches; saturates at 16'hFFFF.
xfer_count  out  CNT_W  words popped to out; wraps.

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0; buffer empty; active_mode = 0.
- Generator counter and checker expected value = 0.

Handshakes: valid/ready. A transfer occurs in a cycle with valid && ready high at the rising edge.
- Valid must not depend on ready.
- out_data is held stable while out_valid && !out_ready.

Buffer: first-word-fall-through.
- A word pushed at edge N appears on out_data with out_valid high after edge N; latency 1 cycle.
- full = (fill == DEPTH).
- No bypass: in_ready is never high while full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not empty and not full: fill unchanged.
- Pointers wrap modulo DEPTH.

Mode switching:
- mode is sampled each cycle. active_mode takes the new value only at an edge where fill == 0 and no push occurs in that cycle.
- The rule is applied again every cycle: a pending change waits until the buffer drains, and in LOOP in_ready stays driven normally while waiting.
- Entering GEN clears the generator counter to 0.
- Entering CHECK clears the expected value to 0.

LOOP:
- in_ready = !full.
- Accepted in words are pushed into the buffer.

GEN:
- in_ready = 0.
- When !full, the generator value is pushed each cycle, then incremented modulo 2^WIDTH.

CHECK:
- in_ready = 1 always.
- Accepted words are compared with the expected value and not buffered.
- Match: expected <= in_data + 1.
- Mismatch: err_count increments (saturating) and expected <= in_data + 1, i.e. it resynchronises.
- Buffer drains on the out side only.

Counters:
- err_count is held across mode changes and cleared only by reset.
- xfer_count increments on every out transfer in any mode.

Reset asserted mid-transfer: all state is cleared immediately; buffered data is lost; no partial words appear on out.

Decomposition:
Package glip_loopback_pkg holds:
- localparams MODE_LOOP=2'd0, MODE_GEN=2'd1, MODE_CHECK=2'd2;
- a typedef for the 2-bit mode.

Sub-module glip_loopback_fifo: FWFT synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty/fill and the same clk/rst.

The top level holds the mode register, generator, checker and counters.

Test Plan:
- LOOP, WIDTH=16, DEPTH=16: push 0x0001..0x0010 back-to-back with out_ready=1 -> identical sequence on out, first word one cycle after first push, xfer_count=16, fill never exceeds 1.
- LOOP backpressure: out_ready=0, push 20 words -> in_ready drops after the 16th push, fill=16; then out_ready=1 -> all 20 words emerge in order, no loss or duplication.
- GEN: mode=1 from reset, out_ready toggling 1/0 -> out sequence 0x0000,0x0001,...; 0xFFFF is followed by 0x0000; in_ready stays 0.
- CHECK: mode=2, send 0,1,2,7,8,9 -> err_count=1 (at 7), no further errors; 70000 consecutive bad words -> err_count saturates at 0xFFFF.
- Mode switch pending: LOOP with 5 words buffered and out_ready=0, set mode=1 -> active_mode stays 0 until the 5 words drain, then becomes 1 and generator output starts at 0x0000.
- Reset mid-operation: rst low for one cycle with fill=8 -> fill=0, out_valid=0, xfer_count=0, active_mode=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/glip_loopback_pkg.sv
// Shared mode encoding for the GLIP loopback/traffic block.
package glip_loopback_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LOOP  = 2'd0;
    localparam mode_t MODE_GEN   = 2'd1;
    localparam mode_t MODE_CHECK = 2'd2;

    // Encoding 3 is reserved and behaves as plain loopback.
    function automatic mode_t decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_LOOP : mode_t'(m);
    endfunction

endpackage

// File: rtl/glip_loopback_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, rst (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data valid whenever !empty);
//        full, empty, fill (number of stored words).
module glip_loopback_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             push_ok, pop_ok;

    assign full  = (fill_q == FW'(DEPTH));
    assign empty = (fill_q == '0);
    assign fill  = fill_q;
    // Gated so the read port shows zero while nothing is stored (incl. reset).
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        fill_d = fill_q + FW'(push_ok) - FW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/glip_loopback_buffer.sv
// Loopback / pattern-generator / pattern-checker between GLIP fifo_in and fifo_out.
// Ports: clk, rst (async active-low); mode request;
//        in_data/in_valid/in_ready (from host); out_data/out_valid/out_ready (to host);
//        active_mode, fill, err_count (saturating), xfer_count (wrapping) for debug.
module glip_loopback_buffer
    import glip_loopback_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             active_mode,
    output logic [$clog2(DEPTH):0] fill,
    output logic [15:0]            err_count,
    output logic [CNT_W-1:0]       xfer_count
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;

    mode_t            active_mode_q, active_mode_d, req_mode;
    logic [WIDTH-1:0] gen_q, gen_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [15:0]      err_q, err_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             in_ready_c;
    logic             push, pop, full, empty;
    logic [WIDTH-1:0] push_data;
    logic [FW-1:0]    fifo_fill;

    glip_loopback_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .fill      (fifo_fill)
    );

    assign out_valid   = !empty;
    assign fill        = fifo_fill;
    assign active_mode = active_mode_q;
    assign err_count   = err_q;
    assign xfer_count  = xfer_q;
    // Held low in reset so every output reads zero.
    assign in_ready    = rst && in_ready_c;

    // Mode datapath, buffer control and counters.
    always_comb begin
        req_mode      = decode_mode(mode);
        in_ready_c    = 1'b0;
        push          = 1'b0;
        push_data     = in_data;
        pop           = !empty && out_ready;
        active_mode_d = active_mode_q;
        gen_d         = gen_q;
        exp_d         = exp_q;
        err_d         = err_q;
        xfer_d        = xfer_q;

        case (active_mode_q)
            MODE_GEN: begin
                // Generation pauses while another mode is requested, otherwise
                // the buffer would never drain and the switch could never happen.
                if (req_mode == MODE_GEN && !full) begin
                    push      = 1'b1;
                    push_data = gen_q;
                    gen_d     = gen_q + WIDTH'(1);
                end
            end
            MODE_CHECK: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    if (in_data != exp_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    // Resynchronise on every word, matching or not.
                    exp_d = in_data + WIDTH'(1);
                end
            end
            default: begin
                in_ready_c = !full;
                push       = in_valid && !full;
            end
        endcase

        if (pop) xfer_d = xfer_q + CNT_W'(1);

        // Mode changes only take effect with an empty buffer and no word entering it.
        if (req_mode != active_mode_q && fifo_fill == '0 && !push) begin
            active_mode_d = req_mode;
            if (req_mode == MODE_GEN)   gen_d = '0;
            if (req_mode == MODE_CHECK) exp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_mode_q <= MODE_LOOP;
            gen_q         <= '0;
            exp_q         <= '0;
            err_q         <= '0;
            xfer_q        <= '0;
        end else begin
            active_mode_q <= active_mode_d;
            gen_q         <= gen_d;
            exp_q         <= exp_d;
            err_q         <= err_d;
            xfer_q        <= xfer_d;
        end
    end

endmodule

// File: tb/tb_glip_loopback_buffer.sv
// Directed, scoreboard-based bench for glip_loopback_buffer.
module tb_glip_loopback_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  active_mode;
    logic [4:0]  fill;
    logic [15:0] err_count;
    logic [31:0] xfer_count;

    // Narrow instance so generator wrap-around is reachable in few cycles.
    logic        s_in_ready;
    logic [3:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [1:0]  s_active_mode;
    logic [2:0]  s_fill;
    logic [15:0] s_err_count;
    logic [7:0]  s_xfer_count;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] sb_q[$];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    glip_loopback_buffer #(.WIDTH(16), .DEPTH(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .active_mode(active_mode), .fill(fill),
        .err_count(err_count), .xfer_count(xfer_count)
    );

    glip_loopback_buffer #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut_small (
        .clk(clk), .rst(rst), .mode(2'd1),
        .in_data(4'd0), .in_valid(1'b0), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .active_mode(s_active_mode), .fill(s_fill),
        .err_count(s_err_count), .xfer_count(s_xfer_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; optionally record it as expected on the out side.
    task automatic send(input logic [15:0] w, input bit expect_out);
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                if (expect_out) sb_q.push_back(w);
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            tick();
            if (sb_q.size() == 0) break;
        end
        chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: every out transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en && rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("out_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        int cyc;
        int got;
        bit done;
        rst = 1'b0; mode = 2'd0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b0; s_out_ready = 1'b0;

        // Reset state.
        #2;
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_active_mode", 32'(active_mode), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_xfer", xfer_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // LOOP: 16 words back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i), 1'b1);
            if (i == 1) begin
                chk("loop_first_valid", 32'(out_valid), 32'd1);
                chk("loop_first_data", 32'(out_data), 32'd1);
            end
            chk("loop_fill_le1", 32'(fill <= 5'd1), 32'd1);
        end
        in_valid = 1'b0;
        wait_drain();
        chk("loop_xfer", xfer_count, 32'd16);

        // LOOP backpressure: 20 words, buffer holds 16.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 1'b1);
        in_valid = 1'b0;
        chk("bp_fill_full", 32'(fill), 32'd16);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        chk("bp_no_bypass", 32'(in_ready), 32'd0);
        for (int i = 16; i < 20; i++) send(16'h0100 + 16'(i), 1'b1);
        in_valid = 1'b0;
        wait_drain();
        chk("bp_xfer", xfer_count, 32'd36);

        // Pending mode switch: 5 words buffered, request GEN.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i), 1'b1);
        in_valid = 1'b0;
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_pending_mode", 32'(active_mode), 32'd0);
            chk("sw_pending_fill", 32'(fill), 32'd5);
        end
        for (int i = 0; i < 40; i++) sb_q.push_back(16'(i));
        out_ready = 1'b1;
        cyc = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            cyc = t;
            if (active_mode == 2'd1) break;
        end
        chk("sw_cycles_to_gen", 32'(cyc), 32'd6);
        chk("sw_fill_at_switch", 32'(fill), 32'd0);

        // GEN with out_ready toggling.
        for (int t = 0; t < 300; t++) begin
            out_ready = ~out_ready;
            tick();
            chk("gen_in_ready", 32'(in_ready), 32'd0);
            if (sb_q.size() <= 5) break;
        end
        out_ready = 1'b0;
        chk("gen_progress", 32'(sb_q.size() <= 5), 32'd1);
        mon_en = 1'b0;
        sb_q.delete();

        // Back to LOOP, then fill to 8 and reset mid-operation.
        mode = 2'd0;
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (active_mode == 2'd0) break;
        end
        chk("back_to_loop", 32'(active_mode), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h0300 + 16'(i), 1'b0);
        in_valid = 1'b0;
        chk("mid_fill8", 32'(fill), 32'd8);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_xfer", xfer_count, 32'd0);
        chk("mid_rst_mode", 32'(active_mode), 32'd0);
        tick();
        rst = 1'b1;

        // CHECK: 0,1,2 good, 7 bad, 8,9 good.
        mode = 2'd2;
        tick();
        chk("chk_active_mode", 32'(active_mode), 32'd2);
        chk("chk_in_ready", 32'(in_ready), 32'd1);
        send(16'd0, 1'b0);
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        chk("chk_err_before", 32'(err_count), 32'd0);
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        send(16'd9, 1'b0);
        in_valid = 1'b0;
        chk("chk_err_one", 32'(err_count), 32'd1);
        chk("chk_fill_zero", 32'(fill), 32'd0);
        chk("chk_out_valid", 32'(out_valid), 32'd0);

        // CHECK saturation: a repeated word never matches its successor.
        in_data  = 16'h5555;
        in_valid = 1'b1;
        repeat (100) tick();
        chk("chk_err_101", 32'(err_count), 32'd101);
        repeat (65440) tick();
        in_valid = 1'b0;
        chk("chk_err_sat", 32'(err_count), 32'h0000_FFFF);

        // Narrow GEN instance: sequence wraps 0xF -> 0x0.
        got = 0;
        done = 1'b0;
        for (int t = 0; t < 400; t++) begin
            s_out_ready = ~s_out_ready;
            @(negedge clk);
            if (s_out_valid && s_out_ready) begin
                chk("small_gen_data", 32'(s_out_data), 32'(got % 16));
                got++;
            end
            chk("small_in_ready", 32'(s_in_ready), 32'd0);
            @(posedge clk); #1;
            if (got >= 40) begin
                done = 1'b1;
                break;
            end
        end
        chk("small_gen_count", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
